// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode/funct constants,
// FSM state encoding, datapath mux-select encodings and the decoder output bundle.
package mc_ctrl_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;

    typedef enum logic [1:0] {PcPlus4 = 2'b00, PcBranch = 2'b01, PcJump = 2'b10, PcRs = 2'b11}
        pc_src_e;
    typedef enum logic [1:0] {RegRt = 2'b00, RegRd = 2'b01, RegRa = 2'b10} regdst_e;
    typedef enum logic [1:0] {AluAdd = 2'b00, AluSub = 2'b01, AluOr = 2'b10, AluLui = 2'b11}
        alu_ctr_e;
    typedef enum logic [1:0] {ExtZero = 2'b00, ExtSign = 2'b01, ExtHi = 2'b10} ext_op_e;
    typedef enum logic [1:0] {MemAlu = 2'b00, MemDm = 2'b01, MemPc4 = 2'b10} memtoreg_e;

    typedef enum logic [2:0] {
        ClsAluR, ClsAluI, ClsLoad, ClsStore, ClsBeq, ClsJump, ClsIllegal
    } instr_class_e;

    typedef enum logic [3:0] {
        SFetch, SDecode, SAlu, SAluWb, SMemAdr, SMemRd, SMemWb, SMemWr, SBranch, SJump
    } state_e;

    // Per-op selects produced by the decoder; the FSM decides when they apply.
    typedef struct packed {
        logic     alusrc;
        alu_ctr_e alu_ctr;
        ext_op_e  ext_op;
        regdst_e  regdst;
        pc_src_e  jump_src;
        logic     is_addi;
        logic     is_jal;
    } sel_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. master = controller (drives enables/selects),
// slave = datapath (drives instr and alu flags).
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             upover;
    logic             pc_we;
    logic             ir_we;
    logic [1:0]       pc_src;
    logic [1:0]       regdst;
    logic             alusrc;
    logic [1:0]       alu_ctr;
    logic [1:0]       ext_op;
    logic [1:0]       memtoreg;
    logic             regwrite;
    logic             memwrite;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, zero, upover,
        output pc_we, ir_we, pc_src, regdst, alusrc, alu_ctr, ext_op, memtoreg,
               regwrite, memwrite, instr_done, illegal, instret
    );

    modport slave (
        output instr, zero, upover,
        input  pc_we, ir_we, pc_src, regdst, alusrc, alu_ctr, ext_op, memtoreg,
               regwrite, memwrite, instr_done, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier for the multi-cycle controller.
//  instr_i : 32-bit IR contents
//  cls_o   : instruction class (ALU_R/ALU_I/LOAD/STORE/BEQ/JUMP/ILLEGAL)
//  sel_o   : per-op select bundle (alu/ext/regdst/jump target)
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output instr_class_e cls_o,
    output sel_t         sel_o
);
    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];

    always_comb begin
        cls_o = ClsIllegal;
        sel_o = '0;
        case (op)
            OpRtype: begin
                sel_o.regdst = RegRd;
                case (funct)
                    FnAddu: cls_o = ClsAluR;
                    FnSubu: begin
                        cls_o         = ClsAluR;
                        sel_o.alu_ctr = AluSub;
                    end
                    FnJr: begin
                        cls_o          = ClsJump;
                        sel_o.jump_src = PcRs;
                    end
                    default: ;
                endcase
            end
            OpOri: begin
                cls_o         = ClsAluI;
                sel_o.alusrc  = 1'b1;
                sel_o.alu_ctr = AluOr;
            end
            OpLui: begin
                cls_o         = ClsAluI;
                sel_o.alusrc  = 1'b1;
                sel_o.alu_ctr = AluLui;
                sel_o.ext_op  = ExtHi;
            end
            OpAddi: begin
                cls_o         = ClsAluI;
                sel_o.alusrc  = 1'b1;
                sel_o.ext_op  = ExtSign;
                sel_o.is_addi = 1'b1;
            end
            OpLw:  cls_o = ClsLoad;
            OpSw:  cls_o = ClsStore;
            OpBeq: cls_o = ClsBeq;
            OpJ: begin
                cls_o          = ClsJump;
                sel_o.jump_src = PcJump;
            end
            OpJal: begin
                cls_o          = ClsJump;
                sel_o.jump_src = PcJump;
                sel_o.is_jal   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath. Sequences fetch/decode/exec/mem/wb,
// drives all write enables and mux selects, and counts retired instructions.
//  clk, rst : clock (rising edge), asynchronous active-high reset
//  bus      : mc_ctrl_if.master (instr/zero/upover in; enables, selects, pulses, instret out)
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit          OV_SUPPRESS = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    instr_class_e     cls;
    sel_t             sel;

    logic      pc_we, ir_we, alusrc, regwrite, memwrite, instr_done, illegal;
    pc_src_e   pc_src;
    regdst_e   regdst;
    alu_ctr_e  alu_ctr;
    ext_op_e   ext_op;
    memtoreg_e memtoreg;

    mc_decode u_decode (
        .instr_i (bus.instr),
        .cls_o   (cls),
        .sel_o   (sel)
    );

    always_comb begin
        state_d    = state_q;
        instret_d  = instret_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        pc_src     = PcPlus4;
        regdst     = RegRt;
        alusrc     = 1'b0;
        alu_ctr    = AluAdd;
        ext_op     = ExtZero;
        memtoreg   = MemAlu;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            SFetch: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = SDecode;
            end
            SDecode: begin
                case (cls)
                    ClsAluR, ClsAluI:  state_d = SAlu;
                    ClsLoad, ClsStore: state_d = SMemAdr;
                    ClsBeq:            state_d = SBranch;
                    ClsJump:           state_d = SJump;
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = SFetch;
                    end
                endcase
            end
            SAlu, SAluWb: begin
                alusrc  = sel.alusrc;
                alu_ctr = sel.alu_ctr;
                ext_op  = sel.ext_op;
                if (state_q == SAlu) begin
                    state_d = SAluWb;
                end else begin
                    regdst     = sel.regdst;
                    regwrite   = !(OV_SUPPRESS && sel.is_addi && bus.upover);
                    instr_done = 1'b1;
                    state_d    = SFetch;
                end
            end
            SMemAdr, SMemRd, SMemWr: begin
                // Address selects stay up while dm is read or written.
                alusrc = 1'b1;
                ext_op = ExtSign;
                if (state_q == SMemAdr) begin
                    state_d = (cls == ClsStore) ? SMemWr : SMemRd;
                end else if (state_q == SMemRd) begin
                    state_d = SMemWb;
                end else begin
                    memwrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = SFetch;
                end
            end
            SMemWb: begin
                regwrite   = 1'b1;
                memtoreg   = MemDm;
                instr_done = 1'b1;
                state_d    = SFetch;
            end
            SBranch: begin
                alu_ctr    = AluSub;
                pc_src     = PcBranch;
                pc_we      = bus.zero;
                instr_done = 1'b1;
                state_d    = SFetch;
            end
            SJump: begin
                pc_we  = 1'b1;
                pc_src = sel.jump_src;
                if (sel.is_jal) begin
                    // PC already holds PC+4 from fetch, so the link value is the PC.
                    regwrite = 1'b1;
                    regdst   = RegRa;
                    memtoreg = MemPc4;
                end
                instr_done = 1'b1;
                state_d    = SFetch;
            end
            default: state_d = SFetch;
        endcase

        if (instr_done && !illegal) begin
            instret_d = instret_q + CNT_W'(1);
        end

        if (rst) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            pc_src     = PcPlus4;
            regdst     = RegRt;
            alusrc     = 1'b0;
            alu_ctr    = AluAdd;
            ext_op     = ExtZero;
            memtoreg   = MemAlu;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SFetch;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pc_we      = pc_we;
    assign bus.ir_we      = ir_we;
    assign bus.pc_src     = pc_src;
    assign bus.regdst     = regdst;
    assign bus.alusrc     = alusrc;
    assign bus.alu_ctr    = alu_ctr;
    assign bus.ext_op     = ext_op;
    assign bus.memtoreg   = memtoreg;
    assign bus.regwrite   = regwrite;
    assign bus.memwrite   = memwrite;
    assign bus.instr_done = instr_done;
    assign bus.illegal    = illegal;
    assign bus.instret    = instret_q;
endmodule
